// File: rtl/ux607_tlfragmenter_param.sv
// TileLink-UL fragmenter: splits A-channel requests larger than 2^MIN_SIZE into aligned
// fragments and rebuilds size/source/addr_lo on D, coalescing Put acks with a sticky error.
module ux607_tlfragmenter_param #(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned MIN_SIZE   = 2,
    parameter int unsigned MAX_SIZE   = 6,
    parameter int unsigned SRC_W      = 2,
    parameter int unsigned ADDR_W     = 30,
    localparam int unsigned DW        = 8 * DATA_BYTES,
    localparam int unsigned FRAG_W    = (MAX_SIZE > MIN_SIZE) ? MAX_SIZE - MIN_SIZE : 1,
    localparam int unsigned LOG_DB    = $clog2(DATA_BYTES),
    localparam int unsigned AL_W      = (LOG_DB < 1) ? 1 : LOG_DB,
    localparam int unsigned BEATS     = (1 << MIN_SIZE) / DATA_BYTES,
    localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int unsigned OSRC_W    = SRC_W + FRAG_W
) (
    input  logic                  clock,
    input  logic                  reset,

    output logic                  in_a_ready,
    input  logic                  in_a_valid,
    input  logic [2:0]            in_a_opcode,
    input  logic [2:0]            in_a_param,
    input  logic [2:0]            in_a_size,
    input  logic [SRC_W-1:0]      in_a_source,
    input  logic [ADDR_W-1:0]     in_a_address,
    input  logic [DATA_BYTES-1:0] in_a_mask,
    input  logic [DW-1:0]         in_a_data,

    input  logic                  out_a_ready,
    output logic                  out_a_valid,
    output logic [2:0]            out_a_opcode,
    output logic [2:0]            out_a_param,
    output logic [2:0]            out_a_size,
    output logic [OSRC_W-1:0]     out_a_source,
    output logic [ADDR_W-1:0]     out_a_address,
    output logic [DATA_BYTES-1:0] out_a_mask,
    output logic [DW-1:0]         out_a_data,

    output logic                  out_d_ready,
    input  logic                  out_d_valid,
    input  logic [2:0]            out_d_opcode,
    input  logic [1:0]            out_d_param,
    input  logic [2:0]            out_d_size,
    input  logic [OSRC_W-1:0]     out_d_source,
    input  logic                  out_d_sink,
    input  logic [AL_W-1:0]       out_d_addr_lo,
    input  logic [DW-1:0]         out_d_data,
    input  logic                  out_d_error,

    input  logic                  in_d_ready,
    output logic                  in_d_valid,
    output logic [2:0]            in_d_opcode,
    output logic [1:0]            in_d_param,
    output logic [2:0]            in_d_size,
    output logic [SRC_W-1:0]      in_d_source,
    output logic                  in_d_sink,
    output logic [AL_W-1:0]       in_d_addr_lo,
    output logic [DW-1:0]         in_d_data,
    output logic                  in_d_error
);

    localparam logic [2:0] OpPutFull = 3'd0;
    localparam logic [2:0] OpGet     = 3'd4;
    localparam logic [2:0] OpAck     = 3'd0;
    localparam logic [2:0] OpAckData = 3'd1;

    // ---------------- A channel ----------------
    logic                  hold_q, hold_d;
    logic [2:0]            hold_opcode_q, hold_param_q, hold_size_q;
    logic [SRC_W-1:0]      hold_source_q;
    logic [ADDR_W-1:0]     hold_address_q;
    logic [FRAG_W-1:0]     gennum_q, gennum_d;
    logic [BEAT_W-1:0]     abeat_q, abeat_d;

    logic [2:0]            cur_opcode, cur_param, cur_size, frag_size;
    logic [SRC_W-1:0]      cur_source;
    logic [ADDR_W-1:0]     cur_address, frag_field, a_align_mask;
    logic                  cur_get, a_last_beat, a_last_frag, out_a_fire, hold_load;
    logic [FRAG_W-1:0]     frag_last_idx, countdown;
    logic [BEAT_W-1:0]     beat_last_idx;

    always_comb begin
        // While a Get is being repeated, fields come from the held copy
        cur_opcode  = hold_q ? hold_opcode_q  : in_a_opcode;
        cur_param   = hold_q ? hold_param_q   : in_a_param;
        cur_size    = hold_q ? hold_size_q    : in_a_size;
        cur_source  = hold_q ? hold_source_q  : in_a_source;
        cur_address = hold_q ? hold_address_q : in_a_address;
        cur_get     = (cur_opcode == OpGet);

        frag_last_idx = '0;
        if (cur_size > 3'(MIN_SIZE)) begin
            frag_last_idx = FRAG_W'((32'd1 << (32'(cur_size) - MIN_SIZE)) - 32'd1);
        end
        frag_size = (cur_size > 3'(MIN_SIZE)) ? 3'(MIN_SIZE) : cur_size;
        beat_last_idx = '0;
        if (!cur_get && frag_size > 3'(LOG_DB)) begin
            beat_last_idx = BEAT_W'((32'd1 << (32'(frag_size) - LOG_DB)) - 32'd1);
        end

        countdown   = frag_last_idx - gennum_q;
        a_last_beat = (abeat_q == beat_last_idx);
        a_last_frag = (gennum_q == frag_last_idx);
        frag_field  = ADDR_W'(frag_last_idx) << MIN_SIZE;

        out_a_valid   = reset & (hold_q | in_a_valid);
        out_a_opcode  = cur_opcode;
        out_a_param   = cur_param;
        out_a_size    = frag_size;
        out_a_source  = {cur_source, countdown};
        out_a_address = (cur_address & ~frag_field) | (ADDR_W'(gennum_q) << MIN_SIZE);
        out_a_mask    = cur_get ? '1 : in_a_mask;
        out_a_data    = in_a_data;
        out_a_fire    = out_a_valid & out_a_ready;

        // A Get is consumed only when its last fragment goes out
        if (cur_get) in_a_ready = reset & out_a_ready & a_last_frag;
        else         in_a_ready = reset & out_a_ready;

        gennum_d  = gennum_q;
        abeat_d   = abeat_q;
        hold_d    = hold_q;
        hold_load = 1'b0;
        if (out_a_fire) begin
            if (a_last_beat) begin
                abeat_d  = '0;
                gennum_d = a_last_frag ? '0 : gennum_q + 1'b1;
            end else begin
                abeat_d  = abeat_q + 1'b1;
            end
            if (cur_get) begin
                hold_d    = !a_last_frag;
                hold_load = !hold_q;
            end
        end

        a_align_mask = (ADDR_W'(1) << in_a_size) - ADDR_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_q         <= 1'b0;
            gennum_q       <= '0;
            abeat_q        <= '0;
            hold_opcode_q  <= OpPutFull;
            hold_param_q   <= '0;
            hold_size_q    <= '0;
            hold_source_q  <= '0;
            hold_address_q <= '0;
        end else begin
            hold_q   <= hold_d;
            gennum_q <= gennum_d;
            abeat_q  <= abeat_d;
            if (hold_load) begin
                hold_opcode_q  <= in_a_opcode;
                hold_param_q   <= in_a_param;
                hold_size_q    <= in_a_size;
                hold_source_q  <= in_a_source;
                hold_address_q <= in_a_address;
            end
        end
    end

    // ---------------- D channel ----------------
    logic [FRAG_W:0]   acknum_q, acknum_d, ack_base;
    logic [BEAT_W-1:0] dbeat_q, dbeat_d, d_last_beat_idx;
    logic [2:0]        dorig_q, dorig_d, first_size, d_frag_size;
    logic              r_error_q, r_error_d;
    logic [FRAG_W-1:0] dcount;
    logic [3:0]        dcount_ones;
    logic              d_is_data, d_is_ack, d_drop, d_first, d_frag_end, d_fire;

    always_comb begin
        dcount    = out_d_source[FRAG_W-1:0];
        d_is_data = (out_d_opcode == OpAckData);
        d_is_ack  = (out_d_opcode == OpAck);
        d_drop    = d_is_ack && (dcount != '0);
        d_first   = (acknum_q == '0);

        // Fragment 0 countdown is 2^k-1, so its popcount is log2 of the fragment count
        dcount_ones = '0;
        for (int i = 0; i < FRAG_W; i++) begin
            dcount_ones = dcount_ones + 4'(dcount[i]);
        end
        first_size = (dcount != '0) ? 3'(MIN_SIZE + 32'(dcount_ones)) : out_d_size;

        d_frag_size = (out_d_size > 3'(MIN_SIZE)) ? 3'(MIN_SIZE) : out_d_size;
        d_last_beat_idx = '0;
        if (d_is_data && d_frag_size > 3'(LOG_DB)) begin
            d_last_beat_idx = BEAT_W'((32'd1 << (32'(d_frag_size) - LOG_DB)) - 32'd1);
        end
        d_frag_end = d_is_data ? (dbeat_q == d_last_beat_idx) : 1'b1;

        out_d_ready  = d_drop | in_d_ready;
        in_d_valid   = out_d_valid & ~d_drop;
        in_d_opcode  = out_d_opcode;
        in_d_param   = out_d_param;
        in_d_sink    = out_d_sink;
        in_d_data    = out_d_data;
        in_d_size    = d_first ? first_size : dorig_q;
        in_d_source  = out_d_source[OSRC_W-1:FRAG_W];
        in_d_error   = out_d_error | r_error_q;
        for (int i = 0; i < AL_W; i++) begin
            in_d_addr_lo[i] = out_d_addr_lo[i] & (i >= int'(in_d_size));
        end

        d_fire    = out_d_valid & out_d_ready;
        ack_base  = d_first ? {1'b0, dcount} + 1'b1 : acknum_q;
        acknum_d  = acknum_q;
        dbeat_d   = dbeat_q;
        dorig_d   = dorig_q;
        r_error_d = r_error_q;
        if (d_fire) begin
            acknum_d = d_frag_end ? ack_base - 1'b1 : ack_base;
            dbeat_d  = (d_is_data && !d_frag_end) ? dbeat_q + 1'b1 : '0;
            if (d_first) dorig_d = first_size;
            if (d_drop)        r_error_d = r_error_q | out_d_error;
            else if (d_is_ack) r_error_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acknum_q  <= '0;
            dbeat_q   <= '0;
            dorig_q   <= '0;
            r_error_q <= 1'b0;
        end else begin
            acknum_q  <= acknum_d;
            dbeat_q   <= dbeat_d;
            dorig_q   <= dorig_d;
            r_error_q <= r_error_d;
        end
    end

    a_size_legal: assert property (@(posedge clock) disable iff (!reset)
        in_a_valid |-> (32'(in_a_size) <= MAX_SIZE))
        else $error("in_a_size exceeds MAX_SIZE");

    a_addr_aligned: assert property (@(posedge clock) disable iff (!reset)
        in_a_valid |-> ((in_a_address & a_align_mask) == '0))
        else $error("in_a_address not aligned to in_a_size");

endmodule

// File: tb/tb_ux607_tlfragmenter_param.sv
// Directed bench for ux607_tlfragmenter_param at default parameters.
module tb_ux607_tlfragmenter_param;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_a_ready, in_a_valid;
    logic [2:0]  in_a_opcode, in_a_param, in_a_size;
    logic [1:0]  in_a_source;
    logic [29:0] in_a_address;
    logic [3:0]  in_a_mask;
    logic [31:0] in_a_data;
    logic        out_a_ready, out_a_valid;
    logic [2:0]  out_a_opcode, out_a_param, out_a_size;
    logic [5:0]  out_a_source;
    logic [29:0] out_a_address;
    logic [3:0]  out_a_mask;
    logic [31:0] out_a_data;
    logic        out_d_ready, out_d_valid;
    logic [2:0]  out_d_opcode, out_d_size;
    logic [1:0]  out_d_param;
    logic [5:0]  out_d_source;
    logic        out_d_sink, out_d_error;
    logic [1:0]  out_d_addr_lo;
    logic [31:0] out_d_data;
    logic        in_d_ready, in_d_valid;
    logic [2:0]  in_d_opcode, in_d_size;
    logic [1:0]  in_d_param, in_d_source, in_d_addr_lo;
    logic        in_d_sink, in_d_error;
    logic [31:0] in_d_data;

    int n_checks = 0;
    int n_pass   = 0;

    ux607_tlfragmenter_param dut (
        .clock(clock), .reset(reset),
        .in_a_ready(in_a_ready), .in_a_valid(in_a_valid), .in_a_opcode(in_a_opcode),
        .in_a_param(in_a_param), .in_a_size(in_a_size), .in_a_source(in_a_source),
        .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_data(in_a_data),
        .out_a_ready(out_a_ready), .out_a_valid(out_a_valid), .out_a_opcode(out_a_opcode),
        .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
        .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
        .out_d_ready(out_d_ready), .out_d_valid(out_d_valid), .out_d_opcode(out_d_opcode),
        .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
        .out_d_sink(out_d_sink), .out_d_addr_lo(out_d_addr_lo), .out_d_data(out_d_data),
        .out_d_error(out_d_error),
        .in_d_ready(in_d_ready), .in_d_valid(in_d_valid), .in_d_opcode(in_d_opcode),
        .in_d_param(in_d_param), .in_d_size(in_d_size), .in_d_source(in_d_source),
        .in_d_sink(in_d_sink), .in_d_addr_lo(in_d_addr_lo), .in_d_data(in_d_data),
        .in_d_error(in_d_error)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                           input logic [29:0] addr);
        in_a_valid   = 1'b1;
        in_a_opcode  = op;
        in_a_size    = sz;
        in_a_source  = src;
        in_a_address = addr;
    endtask

    task automatic drive_d(input logic [2:0] op, input logic [2:0] sz, input logic [5:0] src,
                           input logic err);
        out_d_valid  = 1'b1;
        out_d_opcode = op;
        out_d_size   = sz;
        out_d_source = src;
        out_d_error  = err;
    endtask

    logic [3:0] bp_pat;
    int         frag;

    initial begin
        reset = 1'b0;
        in_a_valid = 1'b0; in_a_opcode = 3'd4; in_a_param = 3'd0; in_a_size = 3'd0;
        in_a_source = 2'd0; in_a_address = '0; in_a_mask = 4'hF; in_a_data = '0;
        out_a_ready = 1'b1;
        out_d_valid = 1'b0; out_d_opcode = 3'd0; out_d_param = 2'd0; out_d_size = 3'd2;
        out_d_source = '0; out_d_sink = 1'b0; out_d_addr_lo = 2'd0; out_d_data = '0;
        out_d_error = 1'b0;
        in_d_ready = 1'b1;

        // Reset holds the A side quiet even with a request pending
        drive_a(3'd4, 3'd4, 2'd1, 30'h100);
        #2;
        check_eq("rst_in_a_ready", in_a_ready, 0);
        check_eq("rst_out_a_valid", out_a_valid, 0);
        in_a_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();

        // Get size 4 -> four fragments
        drive_a(3'd4, 3'd4, 2'd1, 30'h100);
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("get_valid", out_a_valid, 1);
            check_eq("get_size", out_a_size, 2);
            check_eq("get_addr", out_a_address, 30'h100 + 30'(4 * k));
            check_eq("get_src", out_a_source, 6'h10 | 6'(3 - k));
            check_eq("get_mask", out_a_mask, 4'hF);
            check_eq("get_in_ready", in_a_ready, (k == 3));
            tick();
        end
        in_a_valid = 1'b0;
        #1;
        check_eq("get_idle", out_a_valid, 0);
        for (int k = 0; k < 4; k++) begin
            drive_d(3'd1, 3'd2, 6'h10 | 6'(3 - k), 1'b0);
            out_d_data = 32'hD000 + 32'(k);
            #1;
            check_eq("getd_valid", in_d_valid, 1);
            check_eq("getd_size", in_d_size, 4);
            check_eq("getd_src", in_d_source, 1);
            check_eq("getd_data", in_d_data, 32'hD000 + 32'(k));
            tick();
        end
        out_d_valid = 1'b0;

        // PutFull size 3 -> two single-beat fragments
        drive_a(3'd0, 3'd3, 2'd2, 30'h20);
        in_a_data = 32'hAAAA5555;
        #1;
        check_eq("put_addr0", out_a_address, 30'h20);
        check_eq("put_src0", out_a_source, 6'h21);
        check_eq("put_rdy0", in_a_ready, 1);
        check_eq("put_data0", out_a_data, 32'hAAAA5555);
        tick();
        in_a_data = 32'h12345678;
        #1;
        check_eq("put_addr1", out_a_address, 30'h24);
        check_eq("put_src1", out_a_source, 6'h20);
        tick();
        in_a_valid = 1'b0;
        in_d_ready = 1'b0;
        drive_d(3'd0, 3'd2, 6'h21, 1'b0);
        #1;
        check_eq("putd_drop_rdy", out_d_ready, 1);
        check_eq("putd_drop_vld", in_d_valid, 0);
        tick();
        drive_d(3'd0, 3'd2, 6'h20, 1'b0);
        #1;
        check_eq("putd_vld", in_d_valid, 1);
        check_eq("putd_stall_rdy", out_d_ready, 0);
        check_eq("putd_size", in_d_size, 3);
        check_eq("putd_src", in_d_source, 2);
        in_d_ready = 1'b1;
        #1;
        check_eq("putd_rdy", out_d_ready, 1);
        check_eq("putd_err", in_d_error, 0);
        tick();

        // Error coalescing across fragments, then cleared for the next request
        drive_d(3'd0, 3'd2, 6'h21, 1'b1);
        #1;
        check_eq("err_drop_vld", in_d_valid, 0);
        tick();
        drive_d(3'd0, 3'd2, 6'h20, 1'b0);
        #1;
        check_eq("err_sticky", in_d_error, 1);
        check_eq("err_size", in_d_size, 3);
        tick();
        drive_d(3'd0, 3'd2, 6'h20, 1'b0);
        #1;
        check_eq("err_cleared", in_d_error, 0);
        check_eq("err_next_size", in_d_size, 2);
        tick();
        out_d_valid = 1'b0;

        // Sub-fragment Get passes straight through
        drive_a(3'd4, 3'd1, 2'd3, 30'h2);
        #1;
        check_eq("pt_valid", out_a_valid, 1);
        check_eq("pt_size", out_a_size, 1);
        check_eq("pt_src", out_a_source, 6'h30);
        check_eq("pt_addr", out_a_address, 30'h2);
        check_eq("pt_rdy", in_a_ready, 1);
        tick();
        in_a_valid = 1'b0;
        drive_d(3'd1, 3'd1, 6'h30, 1'b0);
        out_d_addr_lo = 2'b11;
        #1;
        check_eq("pt_d_addr_lo", in_d_addr_lo, 2'b10);
        check_eq("pt_d_size", in_d_size, 1);
        check_eq("pt_d_src", in_d_source, 3);
        tick();
        out_d_valid = 1'b0;
        out_d_addr_lo = 2'b00;

        // Backpressure on a size-4 Get: ready pattern 1,0,0,1 repeating
        bp_pat = 4'b1001;
        frag = 0;
        drive_a(3'd4, 3'd4, 2'd2, 30'h200);
        for (int c = 0; c < 20 && frag < 4; c++) begin
            out_a_ready = bp_pat[c % 4];
            #1;
            check_eq("bp_valid", out_a_valid, 1);
            check_eq("bp_addr", out_a_address, 30'h200 + 30'(4 * frag));
            check_eq("bp_src", out_a_source, 6'h20 | 6'(3 - frag));
            check_eq("bp_in_rdy", in_a_ready, out_a_ready && (frag == 3));
            tick();
            if (out_a_ready) frag++;
        end
        in_a_valid = 1'b0;
        out_a_ready = 1'b1;
        #1;
        check_eq("bp_idle", out_a_valid, 0);
        tick();

        // Reset after two fragments, with a sticky error pending on D
        drive_a(3'd4, 3'd4, 2'd1, 30'h300);
        drive_d(3'd0, 3'd2, 6'h21, 1'b1);
        #1;
        check_eq("rm_addr0", out_a_address, 30'h300);
        check_eq("rm_drop", out_d_ready, 1);
        tick();
        out_d_valid = 1'b0;
        #1;
        check_eq("rm_addr1", out_a_address, 30'h304);
        tick();
        reset = 1'b0;
        #1;
        check_eq("rm_rst_valid", out_a_valid, 0);
        check_eq("rm_rst_rdy", in_a_ready, 0);
        tick();
        reset = 1'b1;
        #1;
        check_eq("rm_restart_src", out_a_source, 6'h13);
        check_eq("rm_restart_addr", out_a_address, 30'h300);
        in_a_valid = 1'b0;
        drive_d(3'd0, 3'd2, 6'h10, 1'b0);
        #1;
        check_eq("rm_d_valid", in_d_valid, 1);
        check_eq("rm_d_err", in_d_error, 0);
        check_eq("rm_d_size", in_d_size, 2);
        tick();
        out_d_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
